// File: rtl/ws2812_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_frame_scheduler
// Description : Sequences frame transfers on the WS2812 AXI master port.
//               Software requests and a periodic refresh tick merge into one
//               pending flag. Each frame is started with an INIT_AXI_TXN
//               pulse. The block then waits for TXN_DONE, with a timeout and
//               a bounded number of retries. A latch (reset-low) gap is
//               enforced after every attempt.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   ACLK            in   clock
//   ARESETN         in   asynchronous active-low reset
//   frame_req       in   single-cycle software frame request
//   refresh_period  in   auto-refresh period in cycles (0 = disabled)
//   clear_fault     in   pulse; leaves FAULT and drops any pending request
//   INIT_AXI_TXN    out  start pulse to the ws2812 AXI master
//   TXN_DONE        in   master done level
//   ERROR           in   master error flag, sampled on TXN_DONE rising edge
//   busy            out  high in every state except IDLE and FAULT
//   fault           out  sticky fault indication
//   frame_cnt       out  frames completed without error
//   err_cnt         out  failed attempts (errors plus timeouts)
// Configuration
//   WS2812_SCHED_STATS_EN : when defined, frame_cnt / err_cnt are live
//                           counters; otherwise both are tied to zero.
// ============================================================================
module ws2812_frame_scheduler #(
    parameter int INIT_PULSE     = 2,
    parameter int LATCH_CYCLES   = 5000,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int MAX_RETRY      = 3,
    parameter int PERIOD_W       = 24,
    parameter int CNT_W          = 16
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic                frame_req,
    input  logic [PERIOD_W-1:0] refresh_period,
    input  logic                clear_fault,
    output logic                INIT_AXI_TXN,
    input  logic                TXN_DONE,
    input  logic                ERROR,
    output logic                busy,
    output logic                fault,
    output logic [CNT_W-1:0]    frame_cnt,
    output logic [CNT_W-1:0]    err_cnt
);

    // One timer serves both WAIT (timeout) and LATCH (gap), so it is sized
    // for the larger of the two limits.
    localparam int TMAX   = (LATCH_CYCLES > TIMEOUT_CYCLES) ? LATCH_CYCLES : TIMEOUT_CYCLES;
    localparam int TMR_W  = $clog2(TMAX + 1);
    localparam int PLS_W  = $clog2(INIT_PULSE + 1);
    localparam int RTY_W  = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_LATCH  = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    state_t              state;
    logic                pending;
    logic                retry_due;
    logic [RTY_W-1:0]    retry_cnt;
    logic [TMR_W-1:0]    timer;
    logic [PLS_W-1:0]    pulse_cnt;
    logic [PERIOD_W-1:0] period_cnt;
    logic                done_q;

    logic tick;
    logic done_rise;
    logic timeout_hit;
    logic latch_end;
    logic frame_ok;
    logic attempt_fail;
    logic retry_left;

    assign tick        = (refresh_period != '0) &&
                         (period_cnt >= (refresh_period - PERIOD_W'(1)));
    assign done_rise   = TXN_DONE & ~done_q;
    assign timeout_hit = (timer == TMR_W'(TIMEOUT_CYCLES - 1));
    assign latch_end   = (timer == TMR_W'(LATCH_CYCLES - 1));
    // A done edge takes priority over a timeout landing in the same cycle.
    assign frame_ok     = (state == S_WAIT) & done_rise & ~ERROR;
    assign attempt_fail = (state == S_WAIT) &
                          ((done_rise & ERROR) | (~done_rise & timeout_hit));
    assign retry_left   = (retry_cnt < RTY_W'(MAX_RETRY));

    // Free-running refresh period counter; a lowered period is caught by the
    // >= compare in tick, which also restarts the count.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            period_cnt <= '0;
        end else if ((refresh_period == '0) || tick) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + PERIOD_W'(1);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state        <= S_IDLE;
            pending      <= 1'b0;
            retry_due    <= 1'b0;
            retry_cnt    <= '0;
            timer        <= '0;
            pulse_cnt    <= '0;
            done_q       <= 1'b0;
            INIT_AXI_TXN <= 1'b0;
            busy         <= 1'b0;
            fault        <= 1'b0;
        end else begin
            done_q <= TXN_DONE;

            // Requests accumulate into a single flag; the state branches
            // below override this when the request is consumed.
            if (frame_req || tick) begin
                pending <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    retry_cnt <= '0;
                    retry_due <= 1'b0;
                    if (pending || frame_req) begin
                        state     <= S_LAUNCH;
                        pending   <= 1'b0;
                        pulse_cnt <= '0;
                        busy      <= 1'b1;
                    end
                end

                // First LAUNCH cycle raises the pulse, so it is high for
                // INIT_PULSE cycles starting one cycle after entry.
                S_LAUNCH: begin
                    if (pulse_cnt < PLS_W'(INIT_PULSE)) begin
                        INIT_AXI_TXN <= 1'b1;
                        pulse_cnt    <= pulse_cnt + PLS_W'(1);
                    end else begin
                        INIT_AXI_TXN <= 1'b0;
                        state        <= S_WAIT;
                        timer        <= '0;
                    end
                end

                S_WAIT: begin
                    if (frame_ok) begin
                        state     <= S_LATCH;
                        timer     <= '0;
                        retry_cnt <= '0;
                    end else if (attempt_fail) begin
                        if (retry_left) begin
                            retry_cnt <= retry_cnt + RTY_W'(1);
                            retry_due <= 1'b1;
                            state     <= S_LATCH;
                            timer     <= '0;
                        end else begin
                            state <= S_FAULT;
                            busy  <= 1'b0;
                            fault <= 1'b1;
                        end
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                // A pending retry is served before a new frame; the new
                // frame's pending flag survives the retry.
                S_LATCH: begin
                    if (latch_end) begin
                        if (retry_due) begin
                            state     <= S_LAUNCH;
                            retry_due <= 1'b0;
                            pulse_cnt <= '0;
                        end else if (pending) begin
                            state     <= S_LAUNCH;
                            pending   <= 1'b0;
                            retry_cnt <= '0;
                            pulse_cnt <= '0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                S_FAULT: begin
                    if (clear_fault) begin
                        state     <= S_IDLE;
                        fault     <= 1'b0;
                        pending   <= 1'b0;
                        retry_cnt <= '0;
                        retry_due <= 1'b0;
                    end
                end

                default: begin
                    state        <= S_IDLE;
                    INIT_AXI_TXN <= 1'b0;
                    busy         <= 1'b0;
                    fault        <= 1'b0;
                end
            endcase
        end
    end

`ifdef WS2812_SCHED_STATS_EN
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (frame_ok) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
            if (attempt_fail) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign frame_cnt = '0;
    assign err_cnt   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ws2812_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ws2812_frame_scheduler
// Description : Self-checking bench for ws2812_frame_scheduler. A table of
//               per-attempt vectors covers success, error retries, timeouts
//               and fault; hand sequences cover request merging, the refresh
//               period, tick/request coincidence and reset mid-transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ws2812_frame_scheduler;

    localparam int INIT_PULSE     = 2;
    localparam int LATCH_CYCLES   = 50;
    localparam int TIMEOUT_CYCLES = 100;
    localparam int MAX_RETRY      = 3;
    localparam int PERIOD_W       = 24;
    localparam int CNT_W          = 16;

    // Outcome codes after an attempt
    localparam int O_RELAUNCH = 0;
    localparam int O_IDLE     = 1;
    localparam int O_FAULT    = 2;

    logic                ACLK = 1'b0;
    logic                ARESETN;
    logic                frame_req;
    logic [PERIOD_W-1:0] refresh_period;
    logic                clear_fault;
    logic                INIT_AXI_TXN;
    logic                TXN_DONE;
    logic                ERROR;
    logic                busy;
    logic                fault;
    logic [CNT_W-1:0]    frame_cnt;
    logic [CNT_W-1:0]    err_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    ws2812_frame_scheduler #(
        .INIT_PULSE     (INIT_PULSE),
        .LATCH_CYCLES   (LATCH_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .MAX_RETRY      (MAX_RETRY),
        .PERIOD_W       (PERIOD_W),
        .CNT_W          (CNT_W)
    ) dut (
        .ACLK           (ACLK),
        .ARESETN        (ARESETN),
        .frame_req      (frame_req),
        .refresh_period (refresh_period),
        .clear_fault    (clear_fault),
        .INIT_AXI_TXN   (INIT_AXI_TXN),
        .TXN_DONE       (TXN_DONE),
        .ERROR          (ERROR),
        .busy           (busy),
        .fault          (fault),
        .frame_cnt      (frame_cnt),
        .err_cnt        (err_cnt)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit req;       // issue a fresh frame_req before this attempt
        bit clr;       // pulse clear_fault first
        int delay;     // cycles in WAIT before TXN_DONE rises (-1 = never)
        bit err;       // ERROR level with TXN_DONE
        int outcome;   // expected result after the attempt
        int gap;       // expected cycles from done/wait start to outcome
        int frames;    // expected cumulative frame_cnt (stats build)
        int errs;      // expected cumulative err_cnt (stats build)
    } vec_t;

    vec_t tv[9];

    function automatic int ec(input int v);
`ifdef WS2812_SCHED_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Pulse frame_req for one cycle and count cycles until INIT goes high.
    task automatic issue(output int lat);
        frame_req = 1'b1;
        @(negedge ACLK);
        frame_req = 1'b0;
        lat = 0;
        while (!INIT_AXI_TXN && lat < 20) begin
            @(negedge ACLK);
            lat++;
        end
    endtask

    // Called at the first negedge with INIT high; returns its width.
    task automatic measure_width(output int w);
        w = 0;
        while (INIT_AXI_TXN && w < 20) begin
            @(negedge ACLK);
            w++;
        end
    endtask

    // Act as the AXI master for one attempt, optionally injecting extra
    // frame requests while waiting, then classify what the scheduler does.
    task automatic respond(input int delay, input bit err, input int extra,
                           output int outcome, output int gap);
        int c;
        for (int i = 0; i < delay; i++) begin
            frame_req = (i < 2 * extra) && ((i % 2) == 0);
            @(negedge ACLK);
        end
        frame_req = 1'b0;
        if (delay >= 0) begin
            TXN_DONE = 1'b1;
            ERROR    = err;
        end
        c = 0;
        outcome = 3;
        while (outcome == 3 && c < 400) begin
            @(negedge ACLK);
            c++;
            if (c == 2) begin
                TXN_DONE = 1'b0;
                ERROR    = 1'b0;
            end
            if (INIT_AXI_TXN)  outcome = O_RELAUNCH;
            else if (!busy)    outcome = fault ? O_FAULT : O_IDLE;
        end
        gap = c;
    endtask

    initial begin
        int lat, w, o, g;
        int t[3];

        // req clr delay err outcome gap frames errs
        tv[0] = '{1, 0, 30, 0, O_IDLE,     LATCH_CYCLES + 1,                  1, 0};
        tv[1] = '{1, 0, 10, 1, O_RELAUNCH, LATCH_CYCLES + 2,                  1, 1};
        tv[2] = '{0, 0, 10, 1, O_RELAUNCH, LATCH_CYCLES + 2,                  1, 2};
        tv[3] = '{0, 0,  5, 0, O_IDLE,     LATCH_CYCLES + 1,                  2, 2};
        tv[4] = '{1, 0, -1, 0, O_RELAUNCH, TIMEOUT_CYCLES + LATCH_CYCLES + 1, 2, 3};
        tv[5] = '{0, 0, -1, 0, O_RELAUNCH, TIMEOUT_CYCLES + LATCH_CYCLES + 1, 2, 4};
        tv[6] = '{0, 0, -1, 0, O_RELAUNCH, TIMEOUT_CYCLES + LATCH_CYCLES + 1, 2, 5};
        tv[7] = '{0, 0, -1, 0, O_FAULT,    TIMEOUT_CYCLES,                    2, 6};
        tv[8] = '{1, 1,  3, 0, O_IDLE,     LATCH_CYCLES + 1,                  3, 6};

        ARESETN        = 1'b0;
        frame_req      = 1'b0;
        refresh_period = '0;
        clear_fault    = 1'b0;
        TXN_DONE       = 1'b0;
        ERROR          = 1'b0;
        repeat (4) @(negedge ACLK);
        check("rst_init",  int'(INIT_AXI_TXN), 0);
        check("rst_busy",  int'(busy), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_frame_cnt", int'(frame_cnt), 0);
        check("rst_err_cnt",   int'(err_cnt), 0);
        ARESETN = 1'b1;
        repeat (5) @(negedge ACLK);

        // ---------------- table-driven attempts ----------------
        for (int i = 0; i < 9; i++) begin
            if (tv[i].clr) begin
                clear_fault = 1'b1;
                @(negedge ACLK);
                clear_fault = 1'b0;
                check("clear_fault", int'(fault), 0);
            end
            if (tv[i].req) begin
                issue(lat);
                check("launch_latency", lat, 1);
            end
            measure_width(w);
            check("init_width", w, INIT_PULSE);
            respond(tv[i].delay, tv[i].err, 0, o, g);
            check("outcome", o, tv[i].outcome);
            check("gap", g, tv[i].gap);
            check("frame_cnt", int'(frame_cnt), ec(tv[i].frames));
            check("err_cnt",   int'(err_cnt),   ec(tv[i].errs));
        end

        // ---------------- request merging during WAIT ----------------
        issue(lat);
        check("merge_latency", lat, 1);
        measure_width(w);
        respond(8, 1'b0, 3, o, g);
        check("merge_relaunch", o, O_RELAUNCH);
        check("merge_gap", g, LATCH_CYCLES + 2);
        measure_width(w);
        check("merge_width", w, INIT_PULSE);
        respond(5, 1'b0, 0, o, g);
        check("merge_single_extra", o, O_IDLE);
        check("merge_frame_cnt", int'(frame_cnt), ec(5));

        // ---------------- periodic refresh ----------------
        refresh_period = PERIOD_W'(300);
        for (int p = 0; p < 3; p++) begin
            int n;
            n = 0;
            while (!INIT_AXI_TXN && n < 400) begin
                @(negedge ACLK);
                n++;
            end
            check("tick_launch_seen", int'(INIT_AXI_TXN), 1);
            t[p] = cyc;
            measure_width(w);
            respond(5, 1'b0, 0, o, g);
            check("tick_outcome", o, O_IDLE);
        end
        check("tick_spacing_1", t[1] - t[0], 300);
        check("tick_spacing_2", t[2] - t[1], 300);
        check("tick_frame_cnt", int'(frame_cnt), ec(8));

        // Tick forced by lowering the period, coincident with frame_req.
        frame_req      = 1'b1;
        refresh_period = PERIOD_W'(1);
        @(negedge ACLK);
        frame_req      = 1'b0;
        refresh_period = '0;
        lat = 0;
        while (!INIT_AXI_TXN && lat < 20) begin
            @(negedge ACLK);
            lat++;
        end
        check("coincide_latency", lat, 1);
        measure_width(w);
        respond(5, 1'b0, 0, o, g);
        check("coincide_one_frame", o, O_IDLE);
        check("coincide_frame_cnt", int'(frame_cnt), ec(9));

        // ---------------- reset during WAIT ----------------
        issue(lat);
        measure_width(w);
        repeat (3) @(negedge ACLK);
        check("pre_reset_busy", int'(busy), 1);
        ARESETN = 1'b0;
        #1;
        check("async_rst_busy",  int'(busy), 0);
        check("async_rst_init",  int'(INIT_AXI_TXN), 0);
        check("async_rst_fault", int'(fault), 0);
        TXN_DONE = 1'b1;
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        issue(lat);
        check("post_reset_latency", lat, 1);
        measure_width(w);
        check("post_reset_width", w, INIT_PULSE);
        repeat (10) @(negedge ACLK);
        check("held_done_no_rise_busy", int'(busy), 1);
        check("held_done_frame_cnt", int'(frame_cnt), ec(0));
        TXN_DONE = 1'b0;
        @(negedge ACLK);
        respond(3, 1'b0, 0, o, g);
        check("post_reset_outcome", o, O_IDLE);
        check("post_reset_gap", g, LATCH_CYCLES + 1);
        check("post_reset_frame_cnt", int'(frame_cnt), ec(1));
        check("post_reset_err_cnt",   int'(err_cnt),   ec(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
